similarity_scheduler: RTL and testbench

//   Round-robin scheduler sharing one similarity engine among NUM_REQ query sources (e.g. per-channel

---
 rtl/similarity_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_similarity_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/similarity_scheduler.sv
// ============================================================================
// similarity_scheduler
// ----------------------------------------------------------------------------
// Shares one similarity engine among NUM_REQ query sources (per-channel
// encoders). A round-robin arbiter picks a pending requester, the scheduler
// captures that requester's query hypervector, starts the engine with a
// one-cycle sim_en pulse, waits for the engine to accept and then finish,
// and returns the engine's label tagged with the requester id. Class HVs go
// straight to the engine; they do not pass through this block.
//
// Parameters
//   NUM_REQ     number of requesters (>= 2)
//   DIMENSIONS  hypervector width in bits (must match the engine)
//
// Ports
//   clk          rising-edge clock
//   nrst         synchronous active-low reset
//   req          level request per requester; its HV must be valid while high
//   hv_in        packed query HVs, requester i at [i*DIMENSIONS +: DIMENSIONS]
//   grant        one-hot, one-cycle pulse: query accepted and captured
//   busy         high from the grant cycle up to and including resp_valid
//   resp_valid   one-cycle pulse: resp_id / resp_label valid
//   resp_id      requester index of the completed query (held between pulses)
//   resp_label   engine label, 1 = seizure (held between pulses)
//   sim_en       engine start, one-cycle pulse coincident with grant
//   sim_hv_test  captured query HV, stable for the whole engine run
//   sim_done     engine idle/done (1 = idle or result ready)
//   sim_label    engine label, valid when sim_done = 1 after a run
//
// All outputs come straight from registers.
// ============================================================================
module similarity_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DIMENSIONS = 10000
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DIMENSIONS-1:0]   hv_in,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output logic                            resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id,
  output logic                            resp_label,
  output logic                            sim_en,
  output logic [DIMENSIONS-1:0]           sim_hv_test,
  input  logic                            sim_done,
  input  logic                            sim_label
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [ID_W-1:0]       r_last;        // most recently granted requester
  logic [ID_W-1:0]       r_id;          // requester owning the current run
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_busy;
  logic                  r_resp_valid;
  logic [ID_W-1:0]       r_resp_id;
  logic                  r_resp_label;
  logic                  r_sim_en;
  logic [DIMENSIONS-1:0] r_hv;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_idx;
  logic [DIMENSIONS-1:0] w_sel_hv;

  state_t                w_state_nxt;
  logic [ID_W-1:0]       w_last_nxt;
  logic [ID_W-1:0]       w_id_nxt;
  logic [NUM_REQ-1:0]    w_grant_nxt;
  logic                  w_busy_nxt;
  logic                  w_resp_valid_nxt;
  logic [ID_W-1:0]       w_resp_id_nxt;
  logic                  w_resp_label_nxt;
  logic                  w_sim_en_nxt;
  logic [DIMENSIONS-1:0] w_hv_nxt;

  // Round-robin search: first pending requester after r_last, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Query HV mux for the arbitration winner (constant slices only).
  always_comb begin
    w_sel_hv = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_hv = hv_in[i*DIMENSIONS +: DIMENSIONS];
      end else begin
        w_sel_hv = w_sel_hv;
      end
    end
  end

  // Next-state and next-output logic of the control FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_id_nxt         = r_id;
    w_grant_nxt      = '0;
    w_busy_nxt       = r_busy;
    w_resp_valid_nxt = 1'b0;
    w_resp_id_nxt    = r_resp_id;
    w_resp_label_nxt = r_resp_label;
    w_sim_en_nxt     = 1'b0;
    w_hv_nxt         = r_hv;

    case (r_state)
      ST_IDLE: begin
        // An engine still busy with a foreign run (or coming out of its own
        // reset) must not be started; requests simply keep waiting.
        if (w_found && sim_done) begin
          w_grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_sim_en_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_hv_nxt     = w_sel_hv;
          w_last_nxt   = w_winner;
          w_id_nxt     = w_winner;
          w_state_nxt  = ST_WAIT_BUSY;
        end else begin
          w_busy_nxt   = 1'b0;
        end
      end

      ST_WAIT_BUSY: begin
        // The edge right after sim_en still sees sim_done=1 from before the
        // start; only a low sim_done proves the engine took the query.
        if (!sim_done) begin
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_state_nxt = ST_WAIT_BUSY;
        end
      end

      ST_WAIT_DONE: begin
        if (sim_done) begin
          w_resp_valid_nxt = 1'b1;
          w_resp_id_nxt    = r_id;
          w_resp_label_nxt = sim_label;
          w_state_nxt      = ST_RESP;
        end else begin
          w_state_nxt      = ST_WAIT_DONE;
        end
      end

      ST_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_last       <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_label <= 1'b0;
      r_sim_en     <= 1'b0;
      r_hv         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_id         <= w_id_nxt;
      r_grant      <= w_grant_nxt;
      r_busy       <= w_busy_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_id    <= w_resp_id_nxt;
      r_resp_label <= w_resp_label_nxt;
      r_sim_en     <= w_sim_en_nxt;
      r_hv         <= w_hv_nxt;
    end
  end

  assign grant       = r_grant;
  assign busy        = r_busy;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_label  = r_resp_label;
  assign sim_en      = r_sim_en;
  assign sim_hv_test = r_hv;

endmodule

// File: tb/tb_similarity_scheduler.sv
// ============================================================================
// tb_similarity_scheduler
// ----------------------------------------------------------------------------
// Bench for similarity_scheduler with NUM_REQ=4, DIMENSIONS=16. A behavioural
// engine (DIM+1 busy cycles, label = query closer to 16'hFFFF than 16'h0000)
// sits on the sim_* side. A reference model predicts grants from request
// snapshots and a round-robin pointer and pushes expected responses into a
// scoreboard queue; a monitor on the falling edge compares every output.
// ============================================================================
module tb_similarity_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DIM     = 16;
  localparam int ID_W    = 2;

  logic                   clk = 1'b0;
  logic                   nrst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*DIM-1:0] hv_in;
  logic [NUM_REQ-1:0]     grant;
  logic                   busy;
  logic                   resp_valid;
  logic [ID_W-1:0]        resp_id;
  logic                   resp_label;
  logic                   sim_en;
  logic [DIM-1:0]         sim_hv_test;
  logic                   sim_done;
  logic                   sim_label;

  int n_tests = 0;
  int n_fail  = 0;

  similarity_scheduler #(.NUM_REQ(NUM_REQ), .DIMENSIONS(DIM)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .hv_in      (hv_in),
    .grant      (grant),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_label (resp_label),
    .sim_en     (sim_en),
    .sim_hv_test(sim_hv_test),
    .sim_done   (sim_done),
    .sim_label  (sim_label)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Nearest class HV: seizure (all ones) when more than half the bits are set.
  function automatic logic seizure_ref(input logic [DIM-1:0] hv);
    return ($countones(hv) > DIM/2);
  endfunction

  function automatic logic [DIM-1:0] slice_of(input logic [NUM_REQ*DIM-1:0] all, input int i);
    return all[i*DIM +: DIM];
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return 0;
  endfunction

  // ---------------- behavioural engine ----------------
  logic eng_done  = 1'b1;
  logic eng_label = 1'b0;
  int   eng_cnt   = 0;
  logic stub_busy = 1'b0;

  assign sim_done  = eng_done & ~stub_busy;
  assign sim_label = eng_label;

  always @(posedge clk) begin
    if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done  <= 1'b1;
        eng_label <= seizure_ref(sim_hv_test);
      end
    end else if (sim_en === 1'b1) begin
      eng_done <= 1'b0;
      eng_cnt  <= DIM + 1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            label;
  } resp_t;

  resp_t              sb_q[$];
  logic               started    = 1'b0;
  logic               m_rst_edge = 1'b0;
  logic               m_free, m_wait_low, m_wait_high, m_resp;
  int                 m_last;
  logic [NUM_REQ-1:0] exp_grant;
  logic               exp_resp;
  logic [DIM-1:0]     m_hv;
  logic [ID_W-1:0]    held_id;
  logic               held_label;
  int                 pick_now;

  assign pick_now = rr_pick(req, m_last);

  always @(posedge clk) begin
    m_rst_edge <= !nrst;
    if (!nrst) begin
      started     <= 1'b1;
      m_free      <= 1'b1;
      m_wait_low  <= 1'b0;
      m_wait_high <= 1'b0;
      m_resp      <= 1'b0;
      m_last      <= NUM_REQ - 1;
      exp_grant   <= '0;
      exp_resp    <= 1'b0;
      m_hv        <= '0;
    end else begin
      exp_grant <= '0;
      exp_resp  <= 1'b0;
      if (m_free && (req != '0) && sim_done) begin
        exp_grant  <= NUM_REQ'(1) << pick_now;
        m_last     <= pick_now;
        m_hv       <= slice_of(hv_in, pick_now);
        m_free     <= 1'b0;
        m_wait_low <= 1'b1;
        sb_q.push_back({ID_W'(pick_now), seizure_ref(slice_of(hv_in, pick_now))});
      end
      if (m_wait_low && !sim_done) begin
        m_wait_low  <= 1'b0;
        m_wait_high <= 1'b1;
      end
      if (m_wait_high && sim_done) begin
        m_wait_high <= 1'b0;
        m_resp      <= 1'b1;
        exp_resp    <= 1'b1;
      end
      if (m_resp) begin
        m_resp <= 1'b0;
        m_free <= 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("grant", grant, exp_grant);
      chk("sim_en", sim_en, |exp_grant);
      chk("busy", busy, !m_free);
      chk("resp_valid", resp_valid, exp_resp);
      chk("sim_hv_test", sim_hv_test, m_hv);
      if (resp_valid === 1'b1) begin
        if (m_rst_edge || sb_q.size() == 0) begin
          chk("resp_unexpected", 1'b1, 1'b0);
        end else begin
          chk("resp_id", resp_id, sb_q[0].id);
          chk("resp_label", resp_label, sb_q[0].label);
          held_id    <= sb_q[0].id;
          held_label <= sb_q[0].label;
          void'(sb_q.pop_front());
        end
      end else begin
        chk("resp_id_hold", resp_id, m_rst_edge ? '0 : held_id);
        chk("resp_label_hold", resp_label, m_rst_edge ? 1'b0 : held_label);
        if (m_rst_edge) begin
          held_id    <= '0;
          held_label <= 1'b0;
        end
      end
      if (m_rst_edge) sb_q.delete();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (grant[i] === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_grant%0d: no grant within %0d cycles", i, budget);
    end
  endtask

  task automatic wait_resp(input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (resp_valid === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_resp: no resp_valid within %0d cycles", budget);
    end
  endtask

  task automatic do_reset(input int cycles);
    nrst = 1'b0;
    repeat (cycles) tick();
    nrst = 1'b1;
  endtask

  function automatic logic [DIM-1:0] rand_hv();
    case ($urandom_range(0, 2))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return DIM'($urandom());
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    nrst  = 1'b0;
    req   = '0;
    hv_in = '0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", grant, 4'b0000);
    chk("reset_resp_id", resp_id, 2'd0);
    nrst = 1'b1;

    // 1 single requester, seizure then non-seizure query
    req = 4'b0100;
    hv_in[2*DIM +: DIM] = 16'hFFFF;
    wait_grant(2, 10);
    req = 4'b0000;
    wait_resp(60);
    chk("t1_id", resp_id, 2'd2);
    chk("t1_label", resp_label, 1'b1);
    tick();
    req = 4'b0100;
    hv_in[2*DIM +: DIM] = 16'h0000;
    wait_grant(2, 10);
    req = 4'b0000;
    wait_resp(60);
    chk("t1b_label", resp_label, 1'b0);

    // 2 round-robin from a fresh pointer
    do_reset(2);
    req = 4'b1111;
    for (int s = 0; s < NUM_REQ; s++) hv_in[s*DIM +: DIM] = rand_hv();
    for (int g = 0; g < 5; g++) wait_grant(g % NUM_REQ, 60);
    req = 4'b0000;
    wait_resp(60);

    // 3 starvation: req[3] served right after the current run of req[0]
    req = 4'b0001;
    wait_grant(0, 60);
    repeat (3) tick();
    req = 4'b1001;
    wait_grant(3, 60);
    req = 4'b0001;
    wait_grant(0, 60);
    req = 4'b0000;
    wait_resp(60);

    // 4 capture: HV changes the cycle after grant; label follows captured HV
    req = 4'b0010;
    hv_in[1*DIM +: DIM] = 16'hFFFF;
    wait_grant(1, 60);
    hv_in[1*DIM +: DIM] = 16'h0000;
    req = 4'b0000;
    wait_resp(60);
    chk("t4_label", resp_label, 1'b1);
    chk("t4_id", resp_id, 2'd1);

    // 5 engine busy: no grant while sim_done is held low
    tick();
    stub_busy = 1'b1;
    req = 4'b0001;
    gcnt = 0;
    repeat (10) begin
      tick();
      if (grant !== 4'b0000 || sim_en !== 1'b0) gcnt++;
    end
    chk("t5_no_grant", gcnt, 0);
    stub_busy = 1'b0;
    wait_grant(0, 5);
    req = 4'b0000;
    wait_resp(60);

    // 6 reset while waiting for the engine
    req = 4'b0001;
    hv_in[0 +: DIM] = 16'hFFFF;
    wait_grant(0, 60);
    req = 4'b0000;
    repeat (5) tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_sim_hv", sim_hv_test, 16'h0000);
    req = 4'b0001;
    wait_grant(0, 60);
    req = 4'b0000;
    wait_resp(60);

    // 7 randomized traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, 15));
      for (int s = 0; s < NUM_REQ; s++) begin
        if ($urandom_range(0, 1) == 0) hv_in[s*DIM +: DIM] = rand_hv();
      end
      tick();
    end

    // drain
    req = 4'b0000;
    for (int c = 0; c < 100 && !(sb_q.size() == 0 && m_free); c++) tick();
    chk("drain_queue", sb_q.size(), 0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
